// File: rtl/mul_div_unit_pkg.sv
// Shared MDU definitions: op encodings, default latencies and control states.
// The E-stage decoder imports this package to build the op field.
package mdu_defs;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mul_div_unit.sv
// Multiply/divide unit owning HI/LO. The result is computed when the op is accepted,
// and held in pend_hi/pend_lo. It is committed after a fixed busy period.
module mul_div_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_wr;
    logic             r_done;

    mdu_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      w_hi_nxt;
    logic [31:0]      w_lo_nxt;
    logic [31:0]      w_pend_hi_nxt;
    logic [31:0]      w_pend_lo_nxt;
    logic             w_pend_wr_nxt;
    logic             w_done_nxt;

    mdu_op_e          w_op;
    logic             w_sdiv;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic [31:0]      w_dvd;
    logic [31:0]      w_dvs;
    logic [31:0]      w_quo;
    logic [31:0]      w_rem;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_res_wr;

    assign w_op = mdu_op_e'(op);

    // ---------------- result datapath ----------------
    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    // A zero divisor is swapped for 1 so the divider never sees it; the result is discarded.
    assign w_sdiv = (w_op == MDU_DIV);
    assign w_dvd  = (w_sdiv && a[31]) ? (32'd0 - a) : a;
    assign w_dvs  = (b == 32'd0) ? 32'd1 : ((w_sdiv && b[31]) ? (32'd0 - b) : b);
    assign w_quo  = w_dvd / w_dvs;
    assign w_rem  = w_dvd % w_dvs;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_wr = 1'b1;
        case (w_op)
            MDU_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            MDU_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            MDU_DIV: begin
                w_res_lo = (a[31] ^ b[31]) ? (32'd0 - w_quo) : w_quo;
                w_res_hi = a[31] ? (32'd0 - w_rem) : w_rem;
                w_res_wr = (b != 32'd0);
            end
            MDU_DIVU: begin
                w_res_lo = w_quo;
                w_res_hi = w_rem;
                w_res_wr = (b != 32'd0);
            end
            default: ;
        endcase
    end

    // ---------------- control: next state ----------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;
        w_done_nxt    = 1'b0;

        if (flush) begin
            // Kill wins over both a new start and a commit on the same edge.
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_pend_hi_nxt = 32'd0;
            w_pend_lo_nxt = 32'd0;
            w_pend_wr_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (w_op)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                w_state_nxt   = ST_RUN;
                                w_cnt_nxt     = (w_op == MDU_DIV || w_op == MDU_DIVU) ? DIV_LAT : MULT_LAT;
                                w_pend_hi_nxt = w_res_hi;
                                w_pend_lo_nxt = w_res_lo;
                                w_pend_wr_nxt = w_res_wr;
                            end
                            MDU_MTHI: w_hi_nxt = a;
                            MDU_MTLO: w_lo_nxt = a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt   = ST_IDLE;
                        w_cnt_nxt     = '0;
                        w_done_nxt    = 1'b1;
                        w_pend_hi_nxt = 32'd0;
                        w_pend_lo_nxt = 32'd0;
                        w_pend_wr_nxt = 1'b0;
                        if (r_pend_wr) begin
                            w_hi_nxt = r_pend_hi;
                            w_lo_nxt = r_pend_lo;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
